// File: rtl/udt_hs_rx_filter.sv
// Store-and-forward filter that passes only complete, well-formed UDT handshake
// packets (HS_BEATS x 64-bit) to the listen stage and counts what it forwards/drops.
module udt_hs_rx_filter #(
    parameter int HS_BEATS = 8,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             core_rst,
    input  logic [63:0]      s_tdata,
    input  logic [7:0]       s_tkeep,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic             s_tlast,
    output logic [63:0]      handshake_tdata,
    output logic [7:0]       handshake_tkeep,
    output logic             handshake_tvalid,
    input  logic             handshake_tready,
    output logic             handshake_tlast,
    output logic [CNT_W-1:0] hs_cnt,
    output logic [CNT_W-1:0] drop_cnt
);
    localparam int               IDX_W    = (HS_BEATS > 1) ? $clog2(HS_BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HS_BEATS - 1);

    typedef enum logic [1:0] {RECV, DISCARD, SEND} state_t;

    state_t           state_q, state_d;
    logic [63:0]      buf_mem [HS_BEATS];
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0] rd_next;
    logic [CNT_W-1:0] hs_cnt_q, hs_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic [63:0]      data_q, data_d;
    logic             mem_we;
    logic             in_fire;
    logic             out_fire;
    logic             beat_bad;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign in_fire  = s_tvalid && ready_q;
    assign out_fire = valid_q && handshake_tready;
    assign rd_next  = rd_idx_q + IDX_W'(1);

    // A beat is bad if the header is not control/handshake, any byte is missing,
    // or tlast does not coincide exactly with the final buffer slot.
    assign beat_bad = ((wr_idx_q == '0) && (!s_tdata[63] || (s_tdata[62:48] != 15'h0000)))
                   || (s_tkeep != 8'hFF)
                   || (s_tlast != (wr_idx_q == LAST_IDX));

    always_ff @(posedge clk or posedge core_rst) begin
        if (core_rst) begin
            state_q <= RECV;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RECV: begin
                if (in_fire) begin
                    if (beat_bad) begin
                        state_d = s_tlast ? RECV : DISCARD;
                    end else if (s_tlast) begin
                        state_d = SEND;
                    end
                end
            end
            DISCARD: begin
                if (in_fire && s_tlast) begin
                    state_d = RECV;
                end
            end
            SEND: begin
                if (out_fire && last_q) begin
                    state_d = RECV;
                end
            end
            default: state_d = RECV;
        endcase
    end

    always_comb begin
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        hs_cnt_d   = hs_cnt_q;
        drop_cnt_d = drop_cnt_q;
        valid_d    = valid_q;
        last_d     = last_q;
        data_d     = data_q;
        mem_we     = 1'b0;
        case (state_q)
            RECV: begin
                if (in_fire) begin
                    mem_we   = 1'b1;
                    wr_idx_d = wr_idx_q + IDX_W'(1);
                    if (beat_bad) begin
                        wr_idx_d = '0;
                        if (s_tlast) begin
                            drop_cnt_d = sat_inc(drop_cnt_q);
                        end
                    end else if (s_tlast) begin
                        // Beat 0 is read now so the first output beat is ready one clock later.
                        wr_idx_d = '0;
                        rd_idx_d = '0;
                        valid_d  = 1'b1;
                        last_d   = (LAST_IDX == '0);
                        data_d   = (wr_idx_q == '0) ? s_tdata : buf_mem[0];
                    end
                end
            end
            DISCARD: begin
                if (in_fire && s_tlast) begin
                    drop_cnt_d = sat_inc(drop_cnt_q);
                    wr_idx_d   = '0;
                end
            end
            SEND: begin
                if (out_fire) begin
                    if (last_q) begin
                        valid_d  = 1'b0;
                        last_d   = 1'b0;
                        data_d   = '0;
                        rd_idx_d = '0;
                        wr_idx_d = '0;
                        hs_cnt_d = sat_inc(hs_cnt_q);
                    end else begin
                        rd_idx_d = rd_next;
                        last_d   = (rd_next == LAST_IDX);
                        data_d   = buf_mem[rd_next];
                    end
                end
            end
            default: ;
        endcase
        ready_d = (state_d != SEND);
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            buf_mem[wr_idx_q] <= s_tdata;
        end
    end

    always_ff @(posedge clk or posedge core_rst) begin
        if (core_rst) begin
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            hs_cnt_q   <= '0;
            drop_cnt_q <= '0;
            ready_q    <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            data_q     <= '0;
        end else begin
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            hs_cnt_q   <= hs_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            data_q     <= data_d;
        end
    end

    assign s_tready         = ready_q;
    assign handshake_tvalid = valid_q;
    assign handshake_tlast  = last_q;
    assign handshake_tdata  = data_q;
    assign handshake_tkeep  = {8{valid_q}};
    assign hs_cnt           = hs_cnt_q;
    assign drop_cnt         = drop_cnt_q;

endmodule

// File: tb/tb_udt_hs_rx_filter.sv
// Directed bench for udt_hs_rx_filter: packet-level model plus per-cycle output compare.
module tb_udt_hs_rx_filter;
    localparam int HS_BEATS = 8;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             core_rst;
    logic [63:0]      s_tdata;
    logic [7:0]       s_tkeep;
    logic             s_tvalid;
    logic             s_tready;
    logic             s_tlast;
    logic [63:0]      handshake_tdata;
    logic [7:0]       handshake_tkeep;
    logic             handshake_tvalid;
    logic             handshake_tready;
    logic             handshake_tlast;
    logic [CNT_W-1:0] hs_cnt;
    logic [CNT_W-1:0] drop_cnt;

    udt_hs_rx_filter #(.HS_BEATS(HS_BEATS), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .core_rst         (core_rst),
        .s_tdata          (s_tdata),
        .s_tkeep          (s_tkeep),
        .s_tvalid         (s_tvalid),
        .s_tready         (s_tready),
        .s_tlast          (s_tlast),
        .handshake_tdata  (handshake_tdata),
        .handshake_tkeep  (handshake_tkeep),
        .handshake_tvalid (handshake_tvalid),
        .handshake_tready (handshake_tready),
        .handshake_tlast  (handshake_tlast),
        .hs_cnt           (hs_cnt),
        .drop_cnt         (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Packet-level model state
    logic [63:0] exp_q[$];
    logic [63:0] cur_d[$];
    logic [63:0] got_q[$];
    bit          cur_keep_ok = 1'b1;
    int          m_hs = 0;
    int          m_drop = 0;
    int          xfer_cnt = 0;
    int          ncyc = 0;
    int          last_in_cyc = 0;
    int          first_out_cyc = 0;
    bit          prev_valid = 1'b0;
    bit          exp_valid;
    int          rst_edges = 0;
    bit          rdy_toggle = 1'b0;
    int          pkt_tag = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, ncyc);
        end
    endfunction

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    function automatic bit pkt_ok();
        if (cur_d.size() != HS_BEATS) return 1'b0;
        if (!cur_keep_ok) return 1'b0;
        if (cur_d[0][63] != 1'b1) return 1'b0;
        if (cur_d[0][62:48] != 15'h0000) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (core_rst) rst_edges <= 0;
        else          rst_edges <= rst_edges + 1;
    end

    // Compare process: check outputs first, then fold this cycle's handshakes into the model.
    always @(negedge clk) begin
        ncyc++;
        if (core_rst) begin
            chk("rst_s_tready", {63'd0, s_tready}, 64'd0);
            chk("rst_tvalid", {63'd0, handshake_tvalid}, 64'd0);
            chk("rst_tlast", {63'd0, handshake_tlast}, 64'd0);
            chk("rst_tdata", handshake_tdata, 64'd0);
            chk("rst_tkeep", {56'd0, handshake_tkeep}, 64'd0);
            chk("rst_hs_cnt", 64'(hs_cnt), 64'd0);
            chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
            exp_q.delete();
            cur_d.delete();
            got_q.delete();
            cur_keep_ok = 1'b1;
            m_hs = 0;
            m_drop = 0;
            xfer_cnt = 0;
            prev_valid = 1'b0;
        end else begin
            exp_valid = (exp_q.size() != 0);
            chk("tvalid", {63'd0, handshake_tvalid}, {63'd0, exp_valid});
            if (exp_valid) begin
                chk("tdata", handshake_tdata, exp_q[0]);
                chk("tlast", {63'd0, handshake_tlast}, {63'd0, (exp_q.size() == 1)});
                chk("tkeep", {56'd0, handshake_tkeep}, 64'hFF);
                chk("s_tready_send", {63'd0, s_tready}, 64'd0);
            end else if (rst_edges >= 1) begin
                chk("s_tready_idle", {63'd0, s_tready}, 64'd1);
            end
            chk("hs_cnt", 64'(hs_cnt), 64'(m_hs));
            chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
            if (handshake_tvalid && !prev_valid) first_out_cyc = ncyc;
            prev_valid = handshake_tvalid;
            if (exp_valid && handshake_tvalid && handshake_tready) begin
                got_q.push_back(handshake_tdata);
                void'(exp_q.pop_front());
                xfer_cnt++;
                if (exp_q.size() == 0) m_hs = sat(m_hs + 1);
            end
            if (s_tvalid && s_tready) begin
                cur_d.push_back(s_tdata);
                if (s_tkeep != 8'hFF) cur_keep_ok = 1'b0;
                if (s_tlast) begin
                    last_in_cyc = ncyc;
                    if (pkt_ok()) begin
                        foreach (cur_d[i]) exp_q.push_back(cur_d[i]);
                    end else begin
                        m_drop = sat(m_drop + 1);
                    end
                    cur_d.delete();
                    cur_keep_ok = 1'b1;
                end
            end
        end
    end

    initial begin
        handshake_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            handshake_tready = rdy_toggle ? ~handshake_tready : 1'b1;
        end
    end

    task automatic send_pkt(input int n, input logic [63:0] b0, input int keep_bad_at, input bit gaps);
        logic [63:0] d;
        int          wait_c;
        bit          acc;
        $display("pkt tag=%0d beats=%0d beat0=%h keep_bad_at=%0d gaps=%0d", pkt_tag, n, b0, keep_bad_at, gaps);
        for (int i = 0; i < n; i++) begin
            d = (i == 0) ? b0 : {32'hC0DE_0000 + 32'(pkt_tag), 32'(i)};
            s_tdata  = d;
            s_tkeep  = (i == keep_bad_at) ? 8'h0F : 8'hFF;
            s_tlast  = (i == n - 1);
            s_tvalid = 1'b1;
            wait_c   = 0;
            acc      = 1'b0;
            while (!acc && wait_c < 200) begin
                @(negedge clk);
                acc = s_tready;
                @(posedge clk);
                #1;
                wait_c++;
            end
            if (!acc) begin
                chk("in_accept_timeout", 64'd0, 64'd1);
                break;
            end
            if (gaps) begin
                s_tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        pkt_tag++;
    endtask

    task automatic wait_idle();
        int c = 0;
        while (exp_q.size() != 0 && c < 300) begin
            @(negedge clk);
            c++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        core_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        core_rst = 1'b0;
        @(posedge clk);
        #1;
        got_q.delete();
    endtask

    initial begin
        int c;
        core_rst = 1'b1;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        core_rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_hs_cnt", 64'(hs_cnt), 64'd0);
        chk("post_rst_drop_cnt", 64'(drop_cnt), 64'd0);

        // Valid handshake, listener always ready
        send_pkt(8, 64'h8000_0000_0000_0000, -1, 1'b0);
        wait_idle();
        chk("t1_beats", 64'(got_q.size()), 64'd8);
        if (got_q.size() == 8) begin
            chk("t1_beat0", got_q[0], 64'h8000_0000_0000_0000);
            chk("t1_beat7", got_q[7], 64'hC0DE_0000_0000_0007);
        end
        chk("t1_latency", 64'(first_out_cyc - last_in_cyc), 64'd1);
        chk("t1_hs_cnt", 64'(hs_cnt), 64'd1);

        // Data packet dropped
        do_reset();
        send_pkt(8, 64'h0000_1234_5678_9ABC, -1, 1'b0);
        wait_idle();
        chk("t2_drop_cnt", 64'(drop_cnt), 64'd1);
        chk("t2_beats", 64'(got_q.size()), 64'd0);

        // ACK dropped, then back-to-back valid handshake
        do_reset();
        send_pkt(5, 64'h8002_0000_0000_0000, -1, 1'b0);
        send_pkt(8, 64'h8000_0000_DEAD_BEEF, -1, 1'b0);
        wait_idle();
        chk("t3_drop_cnt", 64'(drop_cnt), 64'd1);
        chk("t3_hs_cnt", 64'(hs_cnt), 64'd1);
        if (got_q.size() == 8) chk("t3_beat0", got_q[0], 64'h8000_0000_DEAD_BEEF);
        else                   chk("t3_beats", 64'(got_q.size()), 64'd8);

        // Oversize, bad tkeep, and early tlast
        do_reset();
        send_pkt(12, 64'h8000_0000_0000_0001, -1, 1'b0);
        wait_idle();
        chk("t4_oversize_drop", 64'(drop_cnt), 64'd1);
        send_pkt(8, 64'h8000_0000_0000_0002, 3, 1'b0);
        wait_idle();
        chk("t4_keep_drop", 64'(drop_cnt), 64'd2);
        send_pkt(5, 64'h8000_0000_0000_0003, -1, 1'b0);
        wait_idle();
        chk("t4_short_drop", 64'(drop_cnt), 64'd3);
        chk("t4_beats", 64'(got_q.size()), 64'd0);

        // Listener toggling ready, input with idle gaps
        do_reset();
        rdy_toggle = 1'b1;
        send_pkt(8, 64'h8000_0000_0000_00A5, -1, 1'b1);
        wait_idle();
        rdy_toggle = 1'b0;
        chk("t5_beats", 64'(got_q.size()), 64'd8);
        if (got_q.size() == 8) chk("t5_beat0", got_q[0], 64'h8000_0000_0000_00A5);
        chk("t5_hs_cnt", 64'(hs_cnt), 64'd1);

        // Reset while output beat 4 is presented, then a clean packet
        do_reset();
        send_pkt(8, 64'h8000_0000_0000_0039, -1, 1'b0);
        c = 0;
        while (xfer_cnt < 4 && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("t6_reached_beat4", 64'(xfer_cnt), 64'd4);
        @(posedge clk);
        #1;
        core_rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_tvalid", {63'd0, handshake_tvalid}, 64'd0);
        chk("t6_rst_hs_cnt", 64'(hs_cnt), 64'd0);
        @(posedge clk);
        #1;
        core_rst = 1'b0;
        @(posedge clk);
        #1;
        got_q.delete();
        repeat (4) @(negedge clk);
        chk("t6_no_tail_beats", 64'(got_q.size()), 64'd0);
        @(posedge clk);
        #1;
        send_pkt(8, 64'h8000_0000_0000_0040, -1, 1'b0);
        wait_idle();
        chk("t6_beats", 64'(got_q.size()), 64'd8);
        if (got_q.size() == 8) chk("t6_beat0", got_q[0], 64'h8000_0000_0000_0040);
        chk("t6_hs_cnt", 64'(hs_cnt), 64'd1);

        // drop_cnt saturation
        do_reset();
        for (int i = 0; i < CNT_MAX + 2; i++) begin
            send_pkt(1, 64'h0000_0000_0000_0100 + 64'(i), -1, 1'b0);
        end
        wait_idle();
        chk("t7_drop_sat", 64'(drop_cnt), 64'(CNT_MAX));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
